sram_responder: RTL and testbench

- Memory-side responder for the pixel-memory interface driven by Read_Write; holds the source image and the gradient output image in one byte-wide array.
- Accepts one read or write per handshake, holds busy for a fixed programmable wait-state count, then returns read data with a one-cycle response pulse.
- Sits below Read_Write in the Sobel top level and is the bench's pixel memory; a preload port lets the host or bench load the image before start.

---
 rtl/sobel_mem_pkg.sv | 11 +
 rtl/sram_responder_if.sv | 24 ++
 rtl/sram_array.sv | 30 +++
 rtl/sram_responder.sv | 62 ++++++
 tb/tb_sram_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sobel_mem_pkg.sv
// sobel_mem_pkg: shared types and constants for the pixel-memory responder
package sobel_mem_pkg;
  typedef enum logic [1:0] {
    INSTR_IDLE  = 2'b00,
    INSTR_READ  = 2'b01,
    INSTR_WRITE = 2'b10,
    INSTR_RSVD  = 2'b11
  } instr_t;
  typedef enum logic {IDLE, ACCESS} resp_state_t;
  localparam int LAT_CNT_W = 4;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: initiator-to-memory handshake plus host preload port
interface sram_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        instruction;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] data_w;
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] data_r;
  logic              busy;
  logic              resp_valid;
  modport master (
    output instruction, addr_r, addr_w, data_w, pre_en, pre_addr, pre_data,
    input  data_r, busy, resp_valid
  );
  modport slave (
    input  instruction, addr_r, addr_w, data_w, pre_en, pre_addr, pre_data,
    output data_r, busy, resp_valid
  );
endinterface

// File: rtl/sram_array.sv
// sram_array: single-port byte array, write port shared by preload and commit
module sram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pre_en_i,
  input  logic [ADDR_W-1:0] pre_addr_i,
  input  logic [DATA_W-1:0] pre_data_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  input  logic [DATA_W-1:0] acc_data_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  assign wa = pre_en_i ? pre_addr_i : acc_addr_i;
  assign wd = pre_en_i ? pre_data_i : acc_data_i;
  always_ff @(posedge clk) begin
    if (pre_en_i || wr_en_i) mem[wa] <= wd;
  end
  // contents are never reset, only the read register is
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem[acc_addr_i];
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: wait-state pixel memory, one read/write per handshake
module sram_responder
  import sobel_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic n_rst,
  sram_responder_if.slave bus
);
  resp_state_t          state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 wr_q, wr_d, resp_q, resp_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 idle, pre_go, accept, done;
  always_comb begin
    idle    = state_q == IDLE;
    pre_go  = idle && bus.pre_en;
    accept  = idle && !bus.pre_en && (bus.instruction == INSTR_READ || bus.instruction == INSTR_WRITE);
    done    = !idle && cnt_q == '0;
    state_d = accept ? ACCESS : done ? IDLE : state_q;
    cnt_d   = accept ? LAT_CNT_W'(LATENCY - 1) : (!idle && !done) ? cnt_q - LAT_CNT_W'(1) : cnt_q;
    wr_d    = accept ? bus.instruction == INSTR_WRITE : wr_q;
    addr_d  = accept ? (wr_d ? bus.addr_w : bus.addr_r) : addr_q;
    wdata_d = accept ? bus.data_w : wdata_q;
    resp_d  = done;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end
  sram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk        (clk),
    .n_rst      (n_rst),
    .pre_en_i   (pre_go),
    .pre_addr_i (bus.pre_addr),
    .pre_data_i (bus.pre_data),
    .wr_en_i    (done && wr_q),
    .rd_en_i    (done && !wr_q),
    .acc_addr_i (addr_q),
    .acc_data_i (wdata_q),
    .rd_data_o  (bus.data_r)
  );
  assign bus.busy       = !idle;
  assign bus.resp_valid = resp_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: three responders (LATENCY 2, 4, 1) against a memory-array model
module tb_sram_responder;
  typedef struct {
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  logic       clk = 1'b0;
  logic       n_rst    [3];
  logic [1:0] instr    [3];
  logic [7:0] addr_r   [3];
  logic [7:0] addr_w   [3];
  logic [7:0] data_w   [3];
  logic       pre_en   [3];
  logic [7:0] pre_addr [3];
  logic [7:0] pre_data [3];
  logic [7:0] data_r   [3];
  logic       busy     [3];
  logic       resp     [3];
  int         resp_cnt [3] = '{0, 0, 0};
  int         lat_of   [3] = '{2, 4, 1};
  logic [7:0] ref_mem  [3][256];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : inst
    sram_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    sram_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(g == 0 ? 2 : g == 1 ? 4 : 1)) dut (
      .clk   (clk),
      .n_rst (n_rst[g]),
      .bus   (bus.slave)
    );
    assign bus.instruction = instr[g];
    assign bus.addr_r      = addr_r[g];
    assign bus.addr_w      = addr_w[g];
    assign bus.data_w      = data_w[g];
    assign bus.pre_en      = pre_en[g];
    assign bus.pre_addr    = pre_addr[g];
    assign bus.pre_data    = pre_data[g];
    assign data_r[g]       = bus.data_r;
    assign busy[g]         = bus.busy;
    assign resp[g]         = bus.resp_valid;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) if (resp[g] === 1'b1) resp_cnt[g]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [7:0] d);
    pre_en[k]   = 1'b1;
    pre_addr[k] = a;
    pre_data[k] = d;
    tick();
    pre_en[k]   = 1'b0;
    ref_mem[k][a] = d;
  endtask

  // issue, scramble operands once accepted, then time the busy window
  task automatic txn(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    instr[k]  = wr ? 2'b10 : 2'b01;
    addr_r[k] = a;
    addr_w[k] = a;
    data_w[k] = d;
    tick();
    instr[k]  = 2'b00;
    addr_r[k] = a ^ 8'h01;
    addr_w[k] = a ^ 8'h01;
    data_w[k] = ~d;
    while (busy[k] === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy_len", n, lat_of[k]);
    chk("resp_pulse", {31'd0, resp[k]}, 1);
    if (wr) ref_mem[k][a] = d;
    else chk("rdata_model", {24'd0, data_r[k]}, {24'd0, ref_mem[k][a]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vec [8];
    int base;
    bit seen;
    logic [7:0] a, d;
    vec = '{'{1'b1, 8'h80, 8'h01, 8'h00}, '{1'b1, 8'h81, 8'hFE, 8'h00},
            '{1'b0, 8'h80, 8'h00, 8'h01}, '{1'b1, 8'h80, 8'h7E, 8'h00},
            '{1'b0, 8'h80, 8'h00, 8'h7E}, '{1'b0, 8'h81, 8'h00, 8'hFE},
            '{1'b1, 8'hFF, 8'hAA, 8'h00}, '{1'b0, 8'hFF, 8'h00, 8'hAA}};
    for (int k = 0; k < 3; k++) begin
      n_rst[k] = 1'b0; instr[k] = 2'b00; pre_en[k] = 1'b0;
      addr_r[k] = '0; addr_w[k] = '0; data_w[k] = '0; pre_addr[k] = '0; pre_data[k] = '0;
    end
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", {31'd0, busy[k]}, 0);
      chk("rst_resp", {31'd0, resp[k]}, 0);
      chk("rst_data", {24'd0, data_r[k]}, 0);
    end
    for (int k = 0; k < 3; k++) n_rst[k] = 1'b1;
    tick();
    // preload then read
    preload(0, 8'h10, 8'h5A);
    txn(0, 1'b0, 8'h10, 8'h00);
    chk("preload_read", {24'd0, data_r[0]}, 32'h5A);
    tick();
    // write then back-to-back read in the resp cycle
    txn(0, 1'b1, 8'h20, 8'hC3);
    txn(0, 1'b0, 8'h20, 8'h00);
    chk("wr_then_rd", {24'd0, data_r[0]}, 32'hC3);
    tick();
    // operand change during busy
    preload(0, 8'h30, 8'h11);
    preload(0, 8'h31, 8'h22);
    txn(0, 1'b0, 8'h30, 8'h00);
    chk("operand_hold", {24'd0, data_r[0]}, 32'h11);
    tick();
    // preload beats a same-cycle read
    instr[0] = 2'b01; addr_r[0] = 8'h50;
    pre_en[0] = 1'b1; pre_addr[0] = 8'h50; pre_data[0] = 8'h77;
    tick();
    pre_en[0] = 1'b0;
    ref_mem[0][8'h50] = 8'h77;
    chk("pre_prio_busy", {31'd0, busy[0]}, 0);
    txn(0, 1'b0, 8'h50, 8'h00);
    chk("pre_then_read", {24'd0, data_r[0]}, 32'h77);
    tick();
    // reserved instruction
    base = resp_cnt[0];
    seen = 1'b0;
    instr[0] = 2'b11;
    repeat (5) begin
      tick();
      if (busy[0] !== 1'b0) seen = 1'b1;
    end
    instr[0] = 2'b00;
    tick();
    chk("rsvd_busy", {31'd0, seen}, 0);
    chk("rsvd_resp", resp_cnt[0] - base, 0);
    // table vectors
    for (int i = 0; i < 8; i++) begin
      txn(0, vec[i].wr, vec[i].a, vec[i].d);
      if (!vec[i].wr) chk("vec_rdata", {24'd0, data_r[0]}, {24'd0, vec[i].exp});
    end
    tick();
    // reset mid-write on the LATENCY=4 instance
    preload(1, 8'h40, 8'h00);
    preload(1, 8'h41, 8'h9C);
    txn(1, 1'b0, 8'h41, 8'h00);
    chk("l4_read", {24'd0, data_r[1]}, 32'h9C);
    tick();
    base = resp_cnt[1];
    instr[1] = 2'b10; addr_w[1] = 8'h40; data_w[1] = 8'hFF;
    tick();
    instr[1] = 2'b00;
    tick();
    n_rst[1] = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy[1]}, 0);
    chk("midrst_resp", {31'd0, resp[1]}, 0);
    chk("midrst_data", {24'd0, data_r[1]}, 0);
    tick();
    n_rst[1] = 1'b1;
    repeat (6) tick();
    chk("midrst_no_resp", resp_cnt[1] - base, 0);
    txn(1, 1'b0, 8'h40, 8'h00);
    chk("midrst_not_committed", {24'd0, data_r[1]}, 0);
    tick();
    // LATENCY=1 full-range sweep
    base = resp_cnt[2];
    for (int i = 0; i < 256; i++) txn(2, 1'b1, 8'(i), 8'(i) ^ 8'hA5);
    for (int i = 0; i < 256; i++) begin
      txn(2, 1'b0, 8'(i), 8'h00);
      chk("sweep_rdata", {24'd0, data_r[2]}, {24'd0, 8'(i) ^ 8'hA5});
    end
    tick();
    chk("sweep_resp_cnt", resp_cnt[2] - base, 512);
    // randomized traffic against the array model
    for (int i = 0; i < 16; i++) preload(0, {4'hE, 4'(i)}, 8'($urandom));
    repeat (200) begin
      a = {4'hE, 4'($urandom_range(0, 15))};
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: preload(0, a, d);
        1: txn(0, 1'b1, a, d);
        default: txn(0, 1'b0, a, d);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
